cmd_manager: RTL and testbench
==============================

// Module: cmd_manager
// PURPOSE
//  Assembles a 4-byte command frame (cmd, arg1, arg2, crc) from a byte-serial
//  stream delivered by an upstream byte receiver (e.g. SPI/SD deserialiser).
//  Each new byte is flagged by a level TOGGLE on byte_finished, not a pulse.
//  Frame fields are held on dedicated output registers for the command decoder.
// PARAMETERS
//  none (field width fixed at 8 bits, frame length fixed at 4 bytes)
// PORTS
//  clk            in   1  system clock; all logic on posedge clk
//  reset          in   1  synchronous, active-low reset (0 = reset)
//  en             in   1  capture enable; 1 = accept bytes
//  in_byte        in   8  byte from receiver; valid >=1 clk before toggle
//  byte_finished  in   1  toggles once per completed byte (either edge counts)
//  cmd            out  8  frame byte 0
//  arg1           out  8  frame byte 1
//  arg2           out  8  frame byte 2
//  crc            out  8  frame byte 3
// BEHAVIOUR
//  - Internal regs: bf_q (registered byte_finished), in_q (registered in_byte,
//    loaded every clk), idx[1:0] (next slot 0..3).
//  - Reset (reset==0 at posedge): cmd=arg1=arg2=crc=8'h00, idx=0, in_q=8'h00,
//    bf_q<=byte_finished (no spurious byte after reset release). Reset has
//    priority over en and edges; mid-frame reset discards the partial frame.
//  - Byte event at posedge k: byte_finished != bf_q. bf_q<=byte_finished every
//    clk regardless of en, so toggles while disabled never fire later.
//  - Captured data is in_q (in_byte sampled at posedge k-1): in_byte may change
//    in the same instant as the toggle; the pre-toggle byte is captured.
//  - On event with en==1: slot idx gets in_q (0->cmd,1->arg1,2->arg2,3->crc);
//    register visible after posedge k (1 clk from toggle seen). idx<=idx+1,
//    wraps 3->0; next frame overwrites fields one by one (no double buffer).
//  - en==0: no field writes, idx forced to 0 (re-enable starts at cmd);
//    outputs hold last values.
//  - Min toggle spacing 2 clks; one event per clk at most.
//  - No CRC check here; crc only stored. No other outputs.
// TESTING
//  1 Reset: reset=0 one clk, any inputs -> all outputs 8'h00, idx 0.
//  2 Frame: en=1, bytes 8'h40,8'h12,8'h34,8'h95, toggle every 4 clks, in_byte
//    changing with toggle -> cmd=40 arg1=12 arg2=34 crc=95, each 1 clk after toggle.
//  3 Wrap: continue with 8'h41,8'hAA -> cmd=41, arg1=AA; arg2=34, crc=95 held.
//  4 Disabled: en=0, 3 toggles of 8'hFF -> outputs unchanged; en=1, toggle
//    8'h55 -> cmd=55 (idx restarted).
//  5 Reset mid-frame after 2 bytes -> outputs 00; next toggle lands in cmd;
//    no capture at reset release even if byte_finished level differs from pre-reset.
//  6 Random: 40 random bytes at 4-clk spacing, en=1 -> model compare each field.

Source files
------------

// File: rtl/cmd_manager.sv
// cmd_manager
//   Assembles a 4-byte command frame (cmd, arg1, arg2, crc) from a byte-serial
//   stream. The upstream receiver flags each completed byte with a level toggle
//   on byte_finished, so either edge marks a new byte.
// Ports
//   clk            system clock, all logic on posedge
//   reset          synchronous, active-low reset
//   en             capture enable (1 = accept bytes)
//   in_byte        byte from receiver, valid >=1 clk before its toggle
//   byte_finished  toggles once per completed byte
//   cmd/arg1/arg2/crc  frame bytes 0..3, held until overwritten
module cmd_manager (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] in_byte,
  input  logic       byte_finished,
  output logic [7:0] cmd,
  output logic [7:0] arg1,
  output logic [7:0] arg2,
  output logic [7:0] crc
);

  logic       bf_q;
  logic [7:0] in_q;
  logic [1:0] idx;
  logic       byte_event;

  // A change of level relative to last clock is one completed byte.
  assign byte_event = (byte_finished != bf_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd  <= '0;
      arg1 <= '0;
      arg2 <= '0;
      crc  <= '0;
      idx  <= '0;
      in_q <= '0;
      // Track the live level so reset release never looks like a toggle.
      bf_q <= byte_finished;
    end else begin
      // Always tracked, so toggles seen while disabled are consumed, not deferred.
      bf_q <= byte_finished;
      // in_q lags in_byte by one clock: the receiver may change in_byte in the
      // same instant it toggles, and the pre-toggle byte is the one wanted.
      in_q <= in_byte;
      if (!en) begin
        idx <= '0;
      end else if (byte_event) begin
        case (idx)
          2'd0:    cmd  <= in_q;
          2'd1:    arg1 <= in_q;
          2'd2:    arg2 <= in_q;
          default: crc  <= in_q;
        endcase
        idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_manager.sv
module tb_cmd_manager;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] in_byte;
  logic       byte_finished;
  logic [7:0] cmd, arg1, arg2, crc;

  cmd_manager dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .in_byte       (in_byte),
    .byte_finished (byte_finished),
    .cmd           (cmd),
    .arg1          (arg1),
    .arg2          (arg2),
    .crc           (crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] c;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] cr;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [7:0] m_f[4];
  int unsigned m_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_f[i] = 8'h00;
    m_idx = 0;
  endtask

  task automatic push_expected();
    exp_t e;
    e.c  = m_f[0];
    e.a1 = m_f[1];
    e.a2 = m_f[2];
    e.cr = m_f[3];
    sb.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_cmd"},  {24'd0, cmd},  {24'd0, e.c});
      check({tag, "_arg1"}, {24'd0, arg1}, {24'd0, e.a1});
      check({tag, "_arg2"}, {24'd0, arg2}, {24'd0, e.a2});
      check({tag, "_crc"},  {24'd0, crc},  {24'd0, e.cr});
    end
  endtask

  task automatic set_en(input logic v);
    @(posedge clk); #1;
    en = v;
    if (!v) m_idx = 0;
  endtask

  // Present b, toggle byte_finished one clock later while in_byte changes to
  // junk in the same instant, then compare one clock after the toggle.
  task automatic send_byte(input logic [7:0] b, input string tag);
    @(posedge clk); #1;
    in_byte = b;
    @(posedge clk); #1;
    byte_finished = ~byte_finished;
    in_byte = 8'($urandom);
    if (en) begin
      m_f[m_idx] = b;
      m_idx = (m_idx + 1) % 4;
    end
    push_expected();
    @(posedge clk); #1;
    pop_compare(tag);
    @(posedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cmd"},  {24'd0, cmd},  32'd0);
    check({tag, "_arg1"}, {24'd0, arg1}, 32'd0);
    check({tag, "_arg2"}, {24'd0, arg2}, 32'd0);
    check({tag, "_crc"},  {24'd0, crc},  32'd0);
  endtask

  initial begin
    reset = 1'b0;
    en = 1'b0;
    in_byte = 8'hA5;
    byte_finished = 1'b1;
    model_reset();

    // 1: reset state
    @(posedge clk); #1;
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_zero("reset_release");

    // 2: basic frame
    set_en(1'b1);
    send_byte(8'h40, "frame0");
    send_byte(8'h12, "frame1");
    send_byte(8'h34, "frame2");
    send_byte(8'h95, "frame3");

    // 3: wrap into next frame
    send_byte(8'h41, "wrap0");
    send_byte(8'hAA, "wrap1");

    // 4: disabled toggles are ignored, re-enable restarts at cmd
    set_en(1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'hFF, "disabled");
    set_en(1'b1);
    send_byte(8'h55, "reenable");

    // 5: reset mid-frame, byte_finished level changes during reset
    send_byte(8'h66, "pre_rst1");
    @(posedge clk); #1;
    reset = 1'b0;
    byte_finished = ~byte_finished;
    in_byte = 8'h77;
    model_reset();
    @(posedge clk); #1;
    check_zero("mid_reset");
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_zero("post_reset");
    send_byte(8'h88, "after_rst");
    send_byte(8'h99, "after_rst_arg1");

    // 6: random stream
    for (int i = 0; i < 40; i++) send_byte(8'($urandom), "random");

    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
